dm_ctrl: RTL and testbench

//   Data-memory controller directly downstream of the pipelined CPU's MEM stage. Consumes
//   m_data_addr/m_data_wdata/m_data_byteen, performs byte-enabled word writes, and returns
//   m_data_rdata combinationally.
//   A post-reset clear FSM zeroes the array while holding the CPU via stall.
//   An optional registered write-trace port feeds the checker.

---
 rtl/dm_pkg.sv | 13 +
 rtl/dm_byte_merge.sv | 18 +
 rtl/dm_ctrl.sv | 109 ++++++++++
 tb/tb_dm_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory controller.
package dm_pkg;

  localparam int unsigned DM_BYTEEN_W = 4;
  localparam int unsigned DM_WORD_W   = 32;

  typedef enum logic {DM_CLEAR, DM_READY} dm_state_t;

  function automatic int unsigned dm_idx_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dm_byte_merge.sv
// Byte-lane merge of store data into an existing word.
module dm_byte_merge
  import dm_pkg::*;
(
  input  logic [DM_WORD_W-1:0]   old,
  input  logic [DM_WORD_W-1:0]   wdata,
  input  logic [DM_BYTEEN_W-1:0] byteen,
  output logic [DM_WORD_W-1:0]   merged
);

  always_comb begin
    merged = old;
    for (int unsigned k = 0; k < DM_BYTEEN_W; k++) begin
      if (byteen[k]) merged[8*k +: 8] = wdata[8*k +: 8];
    end
  end

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory controller: post-reset clear sweep, byte-enabled writes, async read.
// Optional registered write-trace port enabled by defining DM_TRACE_EN.
module dm_ctrl
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned CLR_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        stall,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data
);

  localparam int unsigned IW = dm_idx_w(DEPTH);
  localparam int unsigned PW = IW + 1;

  dm_state_t state, state_next;
  logic [PW-1:0] clr_ptr, clr_ptr_next;
  logic          clr_en;

  logic [DM_WORD_W-1:0] mem [DEPTH];
  logic [IW-1:0]        idx;
  logic                 in_range;
  logic [DM_WORD_W-1:0] old_word, merged;
  logic                 we;

  assign idx          = m_data_addr[IW+1:2];
  assign in_range     = (m_data_addr >> 2) < 32'(DEPTH);
  assign old_word     = mem[idx];
  assign clr_ptr_next = clr_ptr + PW'(CLR_WORDS);
  assign we           = reset && (state == DM_READY) && (|m_data_byteen) && in_range;
  assign m_data_rdata = (state == DM_READY && in_range) ? old_word : '0;

  dm_byte_merge u_merge (
    .old    (old_word),
    .wdata  (m_data_wdata),
    .byteen (m_data_byteen),
    .merged (merged)
  );

  always_comb begin
    state_next = state;
    stall      = 1'b1;
    clr_en     = 1'b0;
    unique case (state)
      DM_CLEAR: begin
        clr_en = 1'b1;
        // Pointer is one bit wider than the index so DEPTH itself is representable.
        if (clr_ptr_next == PW'(DEPTH)) state_next = DM_READY;
      end
      DM_READY: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= DM_CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_next;
      if (clr_en) clr_ptr <= clr_ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && clr_en) begin
      for (int unsigned i = 0; i < CLR_WORDS; i++) begin
        mem[clr_ptr[IW-1:0] + IW'(i)] <= '0;
      end
    end else if (we) begin
      mem[idx] <= merged;
    end
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      trace_valid <= 1'b0;
      trace_pc    <= '0;
      trace_addr  <= '0;
      trace_data  <= '0;
    end else begin
      trace_valid <= we;
      if (we) begin
        trace_pc   <= m_inst_addr;
        trace_addr <= {m_data_addr[31:2], 2'b00};
        trace_data <= merged;
      end
    end
  end
`else
  logic unused_pc;
  assign unused_pc   = ^m_inst_addr;
  assign trace_valid = 1'b0;
  assign trace_pc    = '0;
  assign trace_addr  = '0;
  assign trace_data  = '0;
`endif

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl: directed scenarios plus random traffic vs. a behavioural model.
module tb_dm_ctrl;

  localparam int unsigned DEPTH = 4096;
  localparam int unsigned CLRW  = 4;
  localparam int          SWEEP = DEPTH / CLRW;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_data_addr, m_data_wdata, m_inst_addr;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_rdata;
  logic        stall, trace_valid;
  logic [31:0] trace_pc, trace_addr, trace_data;

  int checks   = 0;
  int failures = 0;

  dm_ctrl #(.DEPTH(DEPTH), .CLR_WORDS(CLRW)) dut (
    .clk           (clk),
    .reset         (reset),
    .m_data_addr   (m_data_addr),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_inst_addr   (m_inst_addr),
    .m_data_rdata  (m_data_rdata),
    .stall         (stall),
    .trace_valid   (trace_valid),
    .trace_pc      (trace_pc),
    .trace_addr    (trace_addr),
    .trace_data    (trace_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural model: memory is a plain array that becomes all-zero once a full
  // sweep's worth of unreset cycles has elapsed.
  logic [31:0] mem_m [DEPTH];
  bit          m_live  = 0;
  bit          m_ready = 0;
  int          m_left  = 0;
  logic        tv_m;
  logic [31:0] tpc_m, ta_m, td_m;

  function automatic bit inr(input logic [31:0] a);
    return (a / 4) < DEPTH;
  endfunction

  function automatic logic [31:0] mask_of(input logic [3:0] be);
    logic [31:0] m;
    m = 32'h0;
    if (be[0]) m = m | 32'h0000_00FF;
    if (be[1]) m = m | 32'h0000_FF00;
    if (be[2]) m = m | 32'h00FF_0000;
    if (be[3]) m = m | 32'hFF00_0000;
    return m;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_live  <= 1;
      m_ready <= 0;
      m_left  <= SWEEP;
      tv_m    <= 0;
      tpc_m   <= 0;
      ta_m    <= 0;
      td_m    <= 0;
    end else if (!m_ready) begin
      if (m_left == 1) begin
        m_ready <= 1;
        for (int i = 0; i < DEPTH; i++) mem_m[i] <= 32'h0;
      end
      m_left <= m_left - 1;
      tv_m   <= 0;
    end else if (m_data_byteen != 4'h0 && inr(m_data_addr)) begin
      mem_m[m_data_addr / 4] <= (mem_m[m_data_addr / 4] & ~mask_of(m_data_byteen))
                              | (m_data_wdata & mask_of(m_data_byteen));
      tv_m  <= 1;
      tpc_m <= m_inst_addr;
      ta_m  <= m_data_addr & 32'hFFFF_FFFC;
      td_m  <= (mem_m[m_data_addr / 4] & ~mask_of(m_data_byteen))
             | (m_data_wdata & mask_of(m_data_byteen));
    end else begin
      tv_m <= 0;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("cmp_stall", {31'h0, stall}, {31'h0, !m_ready});
      chk("cmp_rdata", m_data_rdata,
          (m_ready && inr(m_data_addr)) ? mem_m[m_data_addr / 4] : 32'h0);
`ifdef DM_TRACE_EN
      chk("cmp_tvalid", {31'h0, trace_valid}, {31'h0, tv_m});
      chk("cmp_tpc", trace_pc, tpc_m);
      chk("cmp_taddr", trace_addr, ta_m);
      chk("cmp_tdata", trace_data, td_m);
`else
      chk("cmp_tvalid", {31'h0, trace_valid}, 32'h0);
      chk("cmp_tpc", trace_pc, 32'h0);
      chk("cmp_taddr", trace_addr, 32'h0);
      chk("cmp_tdata", trace_data, 32'h0);
`endif
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] pc);
    m_data_addr   = a;
    m_data_wdata  = wd;
    m_data_byteen = be;
    m_inst_addr   = pc;
    #1;
  endtask

  task automatic count_stall(input string name);
    int n;
    n = 0;
    while (stall === 1'b1 && n < 3000) begin
      n++;
      cycle();
    end
    chk(name, 32'(n), 32'(SWEEP));
  endtask

  initial begin
    int r;
    logic [31:0] a;
    reset = 1'b0;
    drive(32'h0, 32'h0, 4'h0, 32'h0);
    repeat (3) cycle();

    // Sweep length and reads during/after clear
    reset = 1'b1;
    #1;
    chk("clear_rdata", m_data_rdata, 32'h0);
    count_stall("sweep_len");
    chk("ready_stall", {31'h0, stall}, 32'h0);
    drive(32'h0, 32'h0, 4'h0, 32'h0);
    chk("read0_after_clear", m_data_rdata, 32'h0);

    // Full-word write then partial lane write with read-during-write
    drive(32'h10, 32'h1234_5678, 4'b1111, 32'h1000);
    chk("rdw_full_old", m_data_rdata, 32'h0);
    cycle();
    drive(32'h10, 32'h0, 4'h0, 32'h0);
    chk("read_full", m_data_rdata, 32'h1234_5678);
    drive(32'h11, 32'h0000_AB00, 4'b0010, 32'h1004);
    chk("rdw_lane_old", m_data_rdata, 32'h1234_5678);
    cycle();
    drive(32'h10, 32'h0, 4'h0, 32'h0);
    chk("read_lane", m_data_rdata, 32'h1234_AB78);

    // Out-of-range write is dropped
    drive(32'h4000, 32'hFFFF_FFFF, 4'b1111, 32'h1008);
    chk("oor_rdata", m_data_rdata, 32'h0);
    cycle();
    drive(32'h4000, 32'h0, 4'h0, 32'h0);
    chk("oor_no_trace", {31'h0, trace_valid}, 32'h0);
    chk("oor_read", m_data_rdata, 32'h0);
    drive(32'h0, 32'h0, 4'h0, 32'h0);
    chk("oor_read0", m_data_rdata, 32'h0);

    // Trace of a committed store
    drive(32'h24, 32'hCAFE_F00D, 4'b1111, 32'h3004);
    cycle();
    drive(32'h24, 32'h0, 4'h0, 32'h0);
`ifdef DM_TRACE_EN
    chk("trace_valid", {31'h0, trace_valid}, 32'h1);
    chk("trace_pc", trace_pc, 32'h3004);
    chk("trace_addr", trace_addr, 32'h24);
    chk("trace_data", trace_data, 32'hCAFE_F00D);
`else
    chk("trace_valid", {31'h0, trace_valid}, 32'h0);
    chk("trace_pc", trace_pc, 32'h0);
    chk("trace_addr", trace_addr, 32'h0);
    chk("trace_data", trace_data, 32'h0);
`endif

    // Random traffic: dense low region, the 0x4000 boundary, and wild addresses
    repeat (1500) begin
      r = $urandom_range(0, 9);
      if (r < 6)      a = 32'($urandom_range(0, 255));
      else if (r < 8) a = 32'h3FF0 + 32'($urandom_range(0, 31));
      else            a = $urandom;
      drive(a, $urandom, 4'($urandom_range(0, 15)), $urandom);
      cycle();
    end

    // Reset mid-sweep restarts a full sweep
    drive(32'h20, 32'hDEAD_BEEF, 4'b1111, 32'h2000);
    cycle();
    drive(32'h20, 32'h0, 4'h0, 32'h0);
    chk("pre_reset_read", m_data_rdata, 32'hDEAD_BEEF);
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    repeat (500) cycle();
    chk("mid_sweep_stall", {31'h0, stall}, 32'h1);
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    #1;
    count_stall("resweep_len");
    drive(32'h20, 32'h0, 4'h0, 32'h0);
    chk("read20_cleared", m_data_rdata, 32'h0);

    repeat (300) begin
      drive(32'($urandom_range(0, 127)), $urandom, 4'($urandom_range(0, 15)), $urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
